fcs_strip_packer: RTL and testbench

Sits directly downstream of the MAC-filtering stage. It consumes the accepted-frame dibit stream (data + FCS, MSb-first per byte) and strips the trailing 32-bit FCS using a 16-dibit delay line. It packs the remaining payload into 32-bit big-endian words and marks the last word of each frame. Each frame ends with a one-cycle summary: payload byte count and an error flag.

---
 rtl/eth_pkg.sv | 13 +
 rtl/dibit_delay_line.sv | 44 ++++
 rtl/fcs_strip_packer.sv | 133 +++++++++++++
 tb/tb_fcs_strip_packer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | eth_pkg : shared constants and types for the dibit frame path     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package eth_pkg;
  localparam int FCS_DIBITS_DEFAULT = 16;
  localparam int DIBITS_PER_WORD    = 16;
  localparam int DIBITS_PER_BYTE    = 4;

  typedef logic [1:0] dibit_t;
endpackage
`default_nettype wire

// File: rtl/dibit_delay_line.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dibit_delay_line : DEPTH-entry dibit shift register with fill     |
// | count; emits the oldest dibit once DEPTH newer ones are held.     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module dibit_delay_line
  import eth_pkg::*;
#(
  parameter int DEPTH = FCS_DIBITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_dibit,
  input  logic       clear,
  output logic       out_valid,
  output logic [1:0] out_dibit
);
  localparam int c_FILL_W = $clog2(DEPTH + 1);

  logic [2*DEPTH-1:0]  r_sr;
  logic [c_FILL_W-1:0] r_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr   <= '0;
      r_fill <= '0;
    end else begin
      if (in_valid) begin
        r_sr <= {r_sr[2*DEPTH-3:0], in_dibit};
      end
      if (clear) begin
        r_fill <= '0;
      end else if (in_valid && (r_fill != c_FILL_W'(DEPTH))) begin
        r_fill <= r_fill + c_FILL_W'(1);
      end
    end
  end

  assign out_valid = (r_fill == c_FILL_W'(DEPTH)) && in_valid;
  assign out_dibit = r_sr[2*DEPTH-1 -: 2];
endmodule
`default_nettype wire

// File: rtl/fcs_strip_packer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fcs_strip_packer : strips the trailing FCS from a dibit frame and |
// | packs the payload into big-endian 32-bit words with a summary.    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fcs_strip_packer
  import eth_pkg::*;
#(
  parameter int FCS_DIBITS = FCS_DIBITS_DEFAULT,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [1:0]           axiid,
  output logic                 axiov,
  output logic [31:0]          axiod,
  output logic                 axiolast,
  output logic [2:0]           axiobytes,
  output logic                 pkt_done,
  output logic [LEN_WIDTH-1:0] pkt_len,
  output logic                 pkt_err
);
  localparam int c_DCNT_W = $clog2(DIBITS_PER_WORD);
  localparam int c_BYTE_W = $clog2(DIBITS_PER_BYTE);

  logic                 r_armed;
  logic                 r_in_frame;
  logic [c_DCNT_W-1:0]  r_dcnt;
  logic [31:0]          r_partial;
  logic [31:0]          r_hold;
  logic                 r_hold_valid;
  logic [LEN_WIDTH-1:0] r_bytes;

  logic                 w_in_valid;
  logic                 w_eof;
  logic                 w_pay_valid;
  dibit_t               w_pay_dibit;
  logic [31:0]          w_word;
  logic [2:0]           w_part_bytes;

  // A frame already running when reset lifts is ignored until the first gap.
  assign w_in_valid   = axiiv && r_armed;
  assign w_eof        = r_in_frame && !axiiv;
  assign w_word       = r_partial | (32'(w_pay_dibit) << (5'd30 - {r_dcnt, 1'b0}));
  assign w_part_bytes = 3'((5'(r_dcnt) + 5'd3) >> 2);

  dibit_delay_line #(
    .DEPTH (FCS_DIBITS)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_dibit  (axiid),
    .clear     (w_eof),
    .out_valid (w_pay_valid),
    .out_dibit (w_pay_dibit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed      <= 1'b0;
      r_in_frame   <= 1'b0;
      r_dcnt       <= '0;
      r_partial    <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_bytes      <= '0;
      axiov        <= 1'b0;
      axiod        <= '0;
      axiolast     <= 1'b0;
      axiobytes    <= '0;
      pkt_done     <= 1'b0;
      pkt_len      <= '0;
      pkt_err      <= 1'b0;
    end else begin
      r_armed    <= r_armed | ~axiiv;
      r_in_frame <= w_in_valid;
      axiov      <= 1'b0;
      axiod      <= '0;
      axiolast   <= 1'b0;
      axiobytes  <= '0;
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
      pkt_err    <= 1'b0;

      if (w_eof) begin
        // Hold and partial are mutually exclusive here: a full word always resets the dibit count.
        if (r_hold_valid) begin
          axiov     <= 1'b1;
          axiod     <= r_hold;
          axiolast  <= 1'b1;
          axiobytes <= 3'd4;
        end else if (r_dcnt != '0) begin
          axiov     <= 1'b1;
          axiod     <= r_partial;
          axiolast  <= 1'b1;
          axiobytes <= w_part_bytes;
        end
        pkt_done     <= 1'b1;
        pkt_len      <= r_bytes;
        pkt_err      <= (r_bytes == '0) || (r_dcnt[c_BYTE_W-1:0] != '0);
        r_dcnt       <= '0;
        r_partial    <= '0;
        r_hold       <= '0;
        r_hold_valid <= 1'b0;
        r_bytes      <= '0;
      end else if (w_pay_valid) begin
        if (r_hold_valid) begin
          axiov        <= 1'b1;
          axiod        <= r_hold;
          axiobytes    <= 3'd4;
          r_hold_valid <= 1'b0;
        end
        // Counting at each byte's first dibit rounds a trailing partial byte up.
        if ((r_dcnt[c_BYTE_W-1:0] == '0) && (r_bytes != '1)) begin
          r_bytes <= r_bytes + LEN_WIDTH'(1);
        end
        if (r_dcnt == c_DCNT_W'(DIBITS_PER_WORD - 1)) begin
          r_hold       <= w_word;
          r_hold_valid <= 1'b1;
          r_partial    <= '0;
          r_dcnt       <= '0;
        end else begin
          r_partial <= w_word;
          r_dcnt    <= r_dcnt + c_DCNT_W'(1);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fcs_strip_packer.sv
`default_nettype none
// Bench for fcs_strip_packer: directed table, multi-cycle corner sequences
// and random frames scored against a frame-level reference model.
module tb_fcs_strip_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [31:0] axiod;
  logic        axiolast;
  logic [2:0]  axiobytes;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        pkt_err;

  fcs_strip_packer #(.FCS_DIBITS(16), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .axiiv     (axiiv),
    .axiid     (axiid),
    .axiov     (axiov),
    .axiod     (axiod),
    .axiolast  (axiolast),
    .axiobytes (axiobytes),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .pkt_err   (pkt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
    logic        done;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic        err;
    int          cyc;
  } done_t;

  typedef struct {
    logic [63:0] pay;
    int          pd;
    int          nbeats;
    logic [31:0] lword;
    logic [2:0]  lbytes;
    int          len;
    logic        err;
  } vec_t;

  beat_t got_beats[$];
  done_t got_dones[$];

  always @(negedge clk) begin
    if (axiov) got_beats.push_back('{axiod, axiolast, axiobytes, pkt_done, cyc});
    if (pkt_done) got_dones.push_back('{pkt_len, pkt_err, cyc});
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [1:0]  pay_q[$];
  logic [1:0]  frame_q[$];
  beat_t       exp_q[$];
  int          exp_len;
  logic        exp_err;
  int          dib_cyc[128];
  int          eof_cyc;
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic set_payload(input logic [63:0] pay, input int pd);
    pay_q.delete();
    for (int i = 0; i < pd; i++) pay_q.push_back(pay[63-2*i -: 2]);
  endtask

  task automatic assemble(input logic [31:0] fcs);
    frame_q.delete();
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
    for (int i = 0; i < 16; i++) frame_q.push_back(fcs[31-2*i -: 2]);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = frame_q[i];
      if (i < 128) dib_cyc[i] = cyc;
    end
    @(posedge clk); #1;
    axiiv   = 1'b0;
    axiid   = 2'b00;
    eof_cyc = cyc;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: payload is everything but the last 16 dibits,
  // cut into 16-dibit words, last word padded and its bytes rounded up.
  task automatic model();
    int p;
    int nw;
    int rem;
    logic [31:0] w;
    p = pay_q.size();
    exp_q.delete();
    nw = (p + 15) / 16;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 16; j++)
        if (k * 16 + j < p) w[31-2*j -: 2] = pay_q[k*16+j];
      rem = p - 16 * k;
      if (rem > 16) rem = 16;
      exp_q.push_back('{w, (k == nw - 1), 3'((rem + 3) / 4), (k == nw - 1), 0});
    end
    exp_len = (p + 3) / 4;
    exp_err = (p == 0) || (p % 4 != 0);
  endtask

  task automatic check_model(input string tag, input int bb, input int db);
    chk({tag, " beats"}, 64'(got_beats.size() - bb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bb + i < got_beats.size()) begin
        chk({tag, " data"},  64'(got_beats[bb+i].data),  64'(exp_q[i].data));
        chk({tag, " last"},  64'(got_beats[bb+i].last),  64'(exp_q[i].last));
        chk({tag, " bytes"}, 64'(got_beats[bb+i].bytes), 64'(exp_q[i].bytes));
        chk({tag, " done"},  64'(got_beats[bb+i].done),  64'(exp_q[i].done));
      end
    end
    chk({tag, " ndone"}, 64'(got_dones.size() - db), 64'd1);
    if (got_dones.size() > db) begin
      chk({tag, " len"}, 64'(got_dones[db].len), 64'(exp_len));
      chk({tag, " err"}, 64'(got_dones[db].err), 64'(exp_err));
    end
  endtask

  initial begin
    int bb;
    int db;
    logic [31:0] rfcs;

    tbl[0] = '{64'hA500_0000_0000_0000,  4, 1, 32'hA500_0000, 3'd1, 1, 1'b0};
    tbl[1] = '{64'h0,                    0, 0, 32'h0,         3'd0, 0, 1'b1};
    tbl[2] = '{64'hD000_0000_0000_0000,  2, 1, 32'hD000_0000, 3'd1, 1, 1'b1};
    tbl[3] = '{64'h0102_0304_0506_0708, 32, 2, 32'h0506_0708, 3'd4, 8, 1'b0};
    tbl[4] = '{64'h1122_3344_0000_0000, 16, 1, 32'h1122_3344, 3'd4, 4, 1'b0};
    tbl[5] = '{64'hAABB_CCDD_EEFF_0000, 24, 2, 32'hEEFF_0000, 3'd2, 6, 1'b0};
    tbl[6] = '{64'h1238_0000_0000_0000,  7, 1, 32'h1238_0000, 3'd2, 2, 1'b1};

    rst = 1'b0; axiiv = 1'b0; axiid = 2'b00;
    drain(4);
    @(negedge clk);
    chk("rst axiov",    64'(axiov),    64'd0);
    chk("rst axiod",    64'(axiod),    64'd0);
    chk("rst pkt_done", 64'(pkt_done), 64'd0);
    chk("rst pkt_len",  64'(pkt_len),  64'd0);
    chk("rst pkt_err",  64'(pkt_err),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drain(2);

    for (int t = 0; t < 7; t++) begin
      set_payload(tbl[t].pay, tbl[t].pd);
      assemble(32'hC0FF_EE11);
      bb = got_beats.size();
      db = got_dones.size();
      send_frame();
      drain(3);
      chk($sformatf("tbl%0d beats", t), 64'(got_beats.size() - bb), 64'(tbl[t].nbeats));
      if (tbl[t].nbeats > 0 && got_beats.size() > bb) begin
        chk($sformatf("tbl%0d lword", t), 64'(got_beats[got_beats.size()-1].data),  64'(tbl[t].lword));
        chk($sformatf("tbl%0d lbytes", t), 64'(got_beats[got_beats.size()-1].bytes), 64'(tbl[t].lbytes));
        chk($sformatf("tbl%0d llast", t), 64'(got_beats[got_beats.size()-1].last),  64'd1);
        chk($sformatf("tbl%0d ldone", t), 64'(got_beats[got_beats.size()-1].done),  64'd1);
      end
      chk($sformatf("tbl%0d ndone", t), 64'(got_dones.size() - db), 64'd1);
      if (got_dones.size() > db) begin
        chk($sformatf("tbl%0d len", t), 64'(got_dones[db].len), 64'(tbl[t].len));
        chk($sformatf("tbl%0d err", t), 64'(got_dones[db].err), 64'(tbl[t].err));
      end
    end

    // First word of a two-word frame must wait for the 33rd input dibit.
    set_payload(64'h0102_0304_0506_0708, 32);
    assemble(32'h1357_9BDF);
    bb = got_beats.size();
    db = got_dones.size();
    send_frame();
    drain(3);
    chk("two beats", 64'(got_beats.size() - bb), 64'd2);
    if (got_beats.size() >= bb + 2) begin
      chk("first data",  64'(got_beats[bb].data),  64'h0102_0304);
      chk("first last",  64'(got_beats[bb].last),  64'd0);
      chk("first bytes", 64'(got_beats[bb].bytes), 64'd4);
      chk("first cycle", 64'(got_beats[bb].cyc),   64'(dib_cyc[32] + 1));
      chk("last cycle",  64'(got_beats[bb+1].cyc), 64'(eof_cyc + 1));
    end
    if (got_dones.size() > db) chk("done cycle", 64'(got_dones[db].cyc), 64'(eof_cyc + 1));

    // Reset asserted mid-frame and released while the frame is still running.
    set_payload(64'hFFEE_DDCC_BBAA_0000, 24);
    assemble(32'h2468_ACE0);
    bb = got_beats.size();
    db = got_dones.size();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = frame_q[i];
      if (i == 10) rst = 1'b0;
      if (i == 12) begin
        chk("inrst axiov",    64'(axiov),    64'd0);
        chk("inrst pkt_done", 64'(pkt_done), 64'd0);
      end
      if (i == 13) rst = 1'b1;
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    drain(3);
    chk("rst frame beats", 64'(got_beats.size() - bb), 64'd0);
    chk("rst frame dones", 64'(got_dones.size() - db), 64'd0);
    set_payload(64'hDEAD_BEEF_0000_0000, 16);
    assemble(32'h0F0F_F0F0);
    model();
    bb = got_beats.size();
    db = got_dones.size();
    send_frame();
    drain(3);
    check_model("post-rst", bb, db);

    // Back-to-back frames separated by a single idle cycle.
    bb = got_beats.size();
    db = got_dones.size();
    set_payload(64'h1122_3344_0000_0000, 16);
    assemble(32'hAAAA_5555);
    send_frame();
    set_payload(64'h5566_7788_0000_0000, 16);
    assemble(32'h5555_AAAA);
    send_frame();
    drain(3);
    chk("b2b beats", 64'(got_beats.size() - bb), 64'd2);
    chk("b2b dones", 64'(got_dones.size() - db), 64'd2);
    if (got_beats.size() >= bb + 2 && got_dones.size() >= db + 2) begin
      chk("b2b data0", 64'(got_beats[bb].data),   64'h1122_3344);
      chk("b2b last0", 64'(got_beats[bb].last),   64'd1);
      chk("b2b data1", 64'(got_beats[bb+1].data), 64'h5566_7788);
      chk("b2b last1", 64'(got_beats[bb+1].last), 64'd1);
      chk("b2b len0",  64'(got_dones[db].len),    64'd4);
      chk("b2b len1",  64'(got_dones[db+1].len),  64'd4);
      chk("b2b err0",  64'(got_dones[db].err),    64'd0);
      chk("b2b err1",  64'(got_dones[db+1].err),  64'd0);
    end

    for (int f = 0; f < 30; f++) begin
      int p;
      p = $urandom_range(0, 60);
      pay_q.delete();
      for (int i = 0; i < p; i++) pay_q.push_back(2'($urandom_range(0, 3)));
      rfcs = $urandom;
      assemble(rfcs);
      model();
      bb = got_beats.size();
      db = got_dones.size();
      send_frame();
      drain($urandom_range(2, 4));
      check_model($sformatf("rnd%0d", f), bb, db);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
